// File: rtl/mor1kx_bht_ctrl_pkg.sv
// Shared encodings for the gshare branch history table controller:
// 2-bit counter values and the table-initialisation FSM states.
package mor1kx_bht_ctrl_pkg;

    typedef logic [1:0] bht_cnt_t;

    localparam bht_cnt_t STRONG_NT = 2'd0;
    localparam bht_cnt_t WEAK_NT   = 2'd1;
    localparam bht_cnt_t WEAK_T    = 2'd2;
    localparam bht_cnt_t STRONG_T  = 2'd3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_INIT = 1'b1
    } init_state_e;

endpackage

// File: rtl/mor1kx_bht_ctrl_satcnt.sv
// Combinational 2-bit saturating counter step, shared by the table write
// path and the predict-side bypass.
module mor1kx_bht_ctrl_satcnt
    import mor1kx_bht_ctrl_pkg::*;
(
    input  bht_cnt_t cnt_i,
    input  logic     taken_i,
    output bht_cnt_t cnt_o
);

    always_comb begin
        // NOTE: default assignment first, so every path drives cnt_o and no latch is inferred.
        cnt_o = cnt_i;
        if (taken_i) begin
            if (cnt_i != STRONG_T) cnt_o = cnt_i + 2'd1;
        end else begin
            if (cnt_i != STRONG_NT) cnt_o = cnt_i - 2'd1;
        end
    end

endmodule

// File: rtl/mor1kx_bht_ctrl.sv
// gshare dynamic branch predictor: 2-bit counter table indexed by PC ^ GHR,
// one-cycle delayed update with bypass, and a post-reset table-clear walk.
module mor1kx_bht_ctrl
    import mor1kx_bht_ctrl_pkg::*;
#(
    parameter int OPTION_OPERAND_WIDTH = 32,
    parameter int BHT_INDEX_WIDTH      = 6,
    parameter int GHR_WIDTH            = 4
) (
    input  logic                            clk,
    input  logic                            rst,

    input  logic                            padv_i,
    input  logic                            op_bf_i,
    input  logic                            op_bnf_i,
    input  logic [9:0]                      immjbr_upper_i,
    input  logic [OPTION_OPERAND_WIDTH-1:0] pc_i,
    output logic                            predicted_flag_o,
    output logic [BHT_INDEX_WIDTH-1:0]      bht_index_o,

    input  logic                            execute_valid_i,
    input  logic                            prev_op_brcond_i,
    input  logic                            prev_predicted_flag_i,
    input  logic                            prev_taken_i,
    input  logic [BHT_INDEX_WIDTH-1:0]      prev_bht_index_i,
    input  logic                            flag_i,
    output logic                            branch_mispredict_o,
    output logic                            init_busy_o
);

    localparam int NUM_ENTRIES = 1 << BHT_INDEX_WIDTH;
    localparam int GHR_W       = (GHR_WIDTH > 0) ? GHR_WIDTH : 1;
    localparam logic [BHT_INDEX_WIDTH-1:0] IDX_ONE  = 1;
    localparam logic [BHT_INDEX_WIDTH-1:0] IDX_LAST = '1;

    bht_cnt_t                   tbl_q [NUM_ENTRIES];
    init_state_e                state_q;
    logic [BHT_INDEX_WIDTH-1:0] init_cnt_q;
    logic                       init_busy_q;

    logic                       upd_valid_q;
    logic [BHT_INDEX_WIDTH-1:0] upd_idx_q;
    logic                       upd_taken_q;
    logic [GHR_W-1:0]           ghr_q;
    logic [GHR_W-1:0]           ghr_d;

    logic [BHT_INDEX_WIDTH-1:0] hist;
    logic [BHT_INDEX_WIDTH-1:0] idx;
    bht_cnt_t                   upd_cnt;
    bht_cnt_t                   cnt_rd;
    logic                       bypass_hit;
    logic                       predict_taken;
    logic                       res;
    logic                       taken_actual;
    logic                       unused_bits;

    // ---------------- Initialisation walk ----------------
    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_INIT;
            init_cnt_q  <= '0;
            init_busy_q <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    init_cnt_q <= init_cnt_q + IDX_ONE;
                    if (init_cnt_q == IDX_LAST) begin
                        state_q     <= ST_IDLE;
                        init_busy_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    init_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign init_busy_o = init_busy_q;

    // ---------------- Resolve and update pipeline ----------------
    assign branch_mispredict_o = prev_op_brcond_i & execute_valid_i &
                                 (flag_i != prev_predicted_flag_i);
    assign res          = execute_valid_i & prev_op_brcond_i & ~init_busy_q;
    assign taken_actual = prev_taken_i ^ branch_mispredict_o;
    assign ghr_d        = GHR_W'({ghr_q, taken_actual});

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            upd_valid_q <= 1'b0;
            upd_idx_q   <= '0;
            upd_taken_q <= 1'b0;
            ghr_q       <= '0;
        end else begin
            upd_valid_q <= res;
            if (res) begin
                upd_idx_q   <= prev_bht_index_i;
                upd_taken_q <= taken_actual;
                ghr_q       <= ghr_d;
            end
        end
    end

    mor1kx_bht_ctrl_satcnt u_satcnt (
        .cnt_i   (tbl_q[upd_idx_q]),
        .taken_i (upd_taken_q),
        .cnt_o   (upd_cnt)
    );

    // NOTE: the counter table has no reset; the walk defines its contents before they are used.
    always_ff @(posedge clk) begin
        if (init_busy_q) begin
            tbl_q[init_cnt_q] <= WEAK_NT;
        end else if (upd_valid_q) begin
            tbl_q[upd_idx_q] <= upd_cnt;
        end
    end

    // ---------------- Predict ----------------
    generate
        if (GHR_WIDTH > 0) begin : g_hist
            assign hist = BHT_INDEX_WIDTH'(ghr_q);
        end else begin : g_nohist
            assign hist = '0;
        end
    endgenerate

    assign idx         = pc_i[BHT_INDEX_WIDTH+1:2] ^ hist;
    assign bht_index_o = idx;

    // A pending write to the same entry is forwarded so the prediction never sees a stale counter.
    assign bypass_hit    = upd_valid_q & (idx == upd_idx_q);
    assign cnt_rd        = bypass_hit ? upd_cnt : tbl_q[idx];
    assign predict_taken = init_busy_q ? immjbr_upper_i[9] : cnt_rd[1];

    assign predicted_flag_o = (op_bf_i & predict_taken) | (op_bnf_i & ~predict_taken);

    assign unused_bits = ^{padv_i, immjbr_upper_i[8:0], pc_i};

endmodule

// File: tb/tb_mor1kx_bht_ctrl.sv
// Directed self-checking bench for mor1kx_bht_ctrl (default parameters:
// 64 entries, 4-bit history); expected values are worked out by hand.
module tb_mor1kx_bht_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        padv_i;
    logic        op_bf_i;
    logic        op_bnf_i;
    logic [9:0]  immjbr_upper_i;
    logic [31:0] pc_i;
    logic        predicted_flag_o;
    logic [5:0]  bht_index_o;
    logic        execute_valid_i;
    logic        prev_op_brcond_i;
    logic        prev_predicted_flag_i;
    logic        prev_taken_i;
    logic [5:0]  prev_bht_index_i;
    logic        flag_i;
    logic        branch_mispredict_o;
    logic        init_busy_o;

    int checks = 0;
    int errors = 0;
    int n;

    mor1kx_bht_ctrl dut (
        .clk                   (clk),
        .rst                   (rst),
        .padv_i                (padv_i),
        .op_bf_i               (op_bf_i),
        .op_bnf_i              (op_bnf_i),
        .immjbr_upper_i        (immjbr_upper_i),
        .pc_i                  (pc_i),
        .predicted_flag_o      (predicted_flag_o),
        .bht_index_o           (bht_index_o),
        .execute_valid_i       (execute_valid_i),
        .prev_op_brcond_i      (prev_op_brcond_i),
        .prev_predicted_flag_i (prev_predicted_flag_i),
        .prev_taken_i          (prev_taken_i),
        .prev_bht_index_i      (prev_bht_index_i),
        .flag_i                (flag_i),
        .branch_mispredict_o   (branch_mispredict_o),
        .init_busy_o           (init_busy_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic predict(input logic bf, input logic bnf, input logic back, input logic [31:0] pc);
        padv_i         = 1'b1;
        op_bf_i        = bf;
        op_bnf_i       = bnf;
        immjbr_upper_i = {back, 9'd0};
        pc_i           = pc;
    endtask

    task automatic resolve(input logic ev, input logic br, input logic ppf, input logic ptk,
                           input logic [5:0] pidx, input logic flag);
        execute_valid_i       = ev;
        prev_op_brcond_i      = br;
        prev_predicted_flag_i = ppf;
        prev_taken_i          = ptk;
        prev_bht_index_i      = pidx;
        flag_i                = flag;
    endtask

    initial begin
        rst = 1'b1;
        predict(0, 0, 0, 32'h0);
        resolve(0, 0, 0, 0, 6'd0, 0);
        #2;
        check("rst_busy", init_busy_o, 1);
        predict(1, 0, 1, 32'h14); #1;
        check("rst_static_bf_back", predicted_flag_o, 1);
        check("rst_no_mispredict", branch_mispredict_o, 0);

        tick; tick;
        rst = 1'b0;
        predict(1, 0, 0, 32'h14); #1;
        check("walk_static_bf_fwd", predicted_flag_o, 0);
        predict(0, 1, 1, 32'h14); #1;
        check("walk_static_bnf_back", predicted_flag_o, 0);
        predict(1, 0, 1, 32'h14);
        // Resolve held through the walk: mispredict is visible, but nothing may be trained.
        resolve(1, 1, 0, 0, 6'd5, 1); #1;
        check("walk_static_bf_back", predicted_flag_o, 1);
        check("walk_mispredict_comb", branch_mispredict_o, 1);
        n = 0;
        while (init_busy_o === 1'b1 && n < 200) begin
            tick;
            n++;
        end
        check("walk_len", n, 64);

        // C0: ghr=0, entry 5 = 01; l.bf mispredicted, actual taken.
        resolve(1, 1, 0, 0, 6'd5, 1);
        predict(1, 0, 0, 32'h14); #1;
        check("c0_idx", bht_index_o, 5);
        check("c0_pred_weak_nt", predicted_flag_o, 0);
        check("c0_mispredict", branch_mispredict_o, 1);
        // C1: ghr=0001, pc 0x10 -> idx 5, bypass gives 10.
        tick;
        resolve(0, 0, 0, 0, 6'd0, 0);
        predict(1, 0, 0, 32'h10); #1;
        check("c1_hist_idx", bht_index_o, 5);
        check("c1_bypass_weak_t", predicted_flag_o, 1);
        check("c1_no_mispredict", branch_mispredict_o, 0);
        // C2: table holds 10; taken resolve, correctly predicted.
        tick;
        resolve(1, 1, 1, 1, 6'd5, 1);
        predict(1, 0, 0, 32'h10); #1;
        check("c2_table_weak_t", predicted_flag_o, 1);
        check("c2_no_mispredict", branch_mispredict_o, 0);
        // C3: ghr=0011, pc 0x18 -> idx 5; bypass 11.
        tick;
        predict(1, 0, 0, 32'h18); #1;
        check("c3_idx", bht_index_o, 5);
        check("c3_bypass_strong_t", predicted_flag_o, 1);
        // C4: ghr=0111, pc 0x08 -> idx 5; bypass of 11 saturates at 11.
        tick;
        predict(1, 0, 0, 32'h08); #1;
        check("c4_idx", bht_index_o, 5);
        check("c4_sat_top_bypass", predicted_flag_o, 1);
        // C5: ghr=1111, pc 0x28 -> idx 5.
        tick;
        resolve(0, 0, 0, 0, 6'd0, 0);
        predict(1, 0, 0, 32'h28); #1;
        check("c5_idx", bht_index_o, 5);
        check("c5_sat_top_bypass", predicted_flag_o, 1);
        // C6: table 11; l.bnf predicts flag 0, real flag 1 -> mispredict, not taken.
        tick;
        predict(1, 0, 0, 32'h28); #1;
        check("c6_sat_hold", predicted_flag_o, 1);
        predict(0, 1, 0, 32'h28);
        resolve(1, 1, 0, 1, 6'd5, 1); #1;
        check("c6_bnf_pred_taken", predicted_flag_o, 0);
        check("c6_bnf_mispredict", branch_mispredict_o, 1);
        // C7: ghr=1110, pc 0x2C -> idx 5; bypass 11->10. l.bf mispredict, not taken.
        tick;
        resolve(1, 1, 1, 1, 6'd5, 0);
        predict(1, 0, 0, 32'h2C); #1;
        check("c7_ghr_shift0_idx", bht_index_o, 5);
        check("c7_dec_bypass", predicted_flag_o, 1);
        check("c7_bf_mispredict", branch_mispredict_o, 1);
        // C8: ghr=1100, pc 0x24 -> idx 5; bypass 10->01.
        tick;
        resolve(0, 0, 0, 0, 6'd0, 0);
        predict(1, 0, 0, 32'h24); #1;
        check("c8_idx", bht_index_o, 5);
        check("c8_dec_weak_nt", predicted_flag_o, 0);
        // C9/C10: two not-taken resolves drive entry 5 to the floor.
        tick;
        resolve(1, 1, 0, 0, 6'd5, 0);
        predict(0, 0, 0, 32'h0); #1;
        check("c9_no_mispredict", branch_mispredict_o, 0);
        tick;
        predict(1, 0, 0, 32'h18); #1;
        check("c10_alias_idx", bht_index_o, 14);
        check("c10_alias_untrained", predicted_flag_o, 0);
        // C11: one taken resolve; C12 bypass from a saturated 00 gives 01.
        tick;
        resolve(1, 1, 1, 1, 6'd5, 1);
        predict(0, 0, 0, 32'h0);
        tick;
        resolve(0, 0, 0, 0, 6'd0, 0);
        predict(1, 0, 0, 32'h10); #1;
        check("c12_idx", bht_index_o, 5);
        check("c12_sat_floor", predicted_flag_o, 0);
        // C13: ghr=0001, pc 0x14 -> idx 4, never trained. Non-branch resolve.
        tick;
        resolve(1, 0, 0, 0, 6'd5, 1);
        predict(1, 0, 0, 32'h14); #1;
        check("c13_neighbor_idx", bht_index_o, 4);
        check("c13_neighbor_untrained", predicted_flag_o, 0);
        check("c13_nonbranch_no_mispredict", branch_mispredict_o, 0);
        // C14: taken resolve leaves an update pending; reset lands on top of it.
        tick;
        resolve(1, 1, 1, 1, 6'd5, 1);
        tick;
        resolve(0, 0, 0, 0, 6'd0, 0);
        rst = 1'b1; #1;
        check("rst_async_busy", init_busy_o, 1);
        predict(1, 0, 0, 32'h14); #1;
        check("rst_ghr_clear_idx", bht_index_o, 5);
        tick;
        rst = 1'b0;
        for (int i = 0; i < 30; i++) tick;
        check("walk30_busy", init_busy_o, 1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        n = 0;
        while (init_busy_o === 1'b1 && n < 200) begin
            tick;
            n++;
        end
        check("rewalk_len", n, 64);
        predict(1, 0, 0, 32'h14); #1;
        check("rewalk_idx", bht_index_o, 5);
        check("rewalk_weak_nt", predicted_flag_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mor1kx_bht_ctrl.md
Name: mor1kx_bht_ctrl

Overview:
- Dynamic branch-prediction controller: a 2^BHT_INDEX_WIDTH-entry table of 2-bit saturating counters, indexed gshare-style by PC XOR global history.
- Produces the predicted flag in the predict stage and schedules the table update when the branch resolves one stage later.
- Sequences a post-reset table initialisation walk; falls back to static prediction until that walk completes.
- Drop-in alongside the static predictor in the fetch/decode to execute path.

Parameters:
- OPTION_OPERAND_WIDTH, 32, PC width.
- BHT_INDEX_WIDTH, 6, log2 of table entries (64).
- GHR_WIDTH, 4, global history bits; must be at most BHT_INDEX_WIDTH; 0 disables history.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- padv_i  in  1  predict stage advances this cycle
- op_bf_i  in  1  predict-stage instruction is l.bf
- op_bnf_i  in  1  predict-stage instruction is l.bnf
- immjbr_upper_i  in  10  upper branch immediate; bit 9 set means backward
- pc_i  in  OPTION_OPERAND_WIDTH  predict-stage PC
- predicted_flag_o  out  1  predicted flag value
- bht_index_o  out  BHT_INDEX_WIDTH  index used; piped with the instruction
- execute_valid_i  in  1  resolve stage holds a valid instruction this cycle
- prev_op_brcond_i  in  1  resolve-stage instruction is a conditional branch
- prev_predicted_flag_i  in  1  flag predicted for it
- prev_bht_index_i  in  BHT_INDEX_WIDTH  its piped index
- flag_i  in  1  real SR[F]
- branch_mispredict_o  out  1  misprediction
- init_busy_o  out  1  table initialisation in progress

Behaviour:
- Index: idx = pc_i[BHT_INDEX_WIDTH+1:2] XOR {zeros, ghr_q}. bht_index_o = idx, combinational.
- Counter read is combinational from a register array. taken = cnt[1].
- predicted_flag_o = op_bf_i&taken | op_bnf_i&!taken.
- While init_busy_o=1, taken = immjbr_upper_i[9] (static: backward taken).
- branch_mispredict_o = prev_op_brcond_i & execute_valid_i & (flag_i != prev_predicted_flag_i). Combinational, zero latency.
- Resolve event: res = execute_valid_i & prev_op_brcond_i & !init_busy_o. Outcome taken_actual = flag_i XNOR op-is-bf. To make this computable, the counter tracks the real flag value: counter "taken" means flag=1 for bf and flag=0 for bnf. Simplification, decided: the counter is trained on the branch-taken sense; the resolve stage supplies the outcome as (flag_i == prev_predicted_flag_i) XNOR prev_taken. The implementation therefore pipes taken alongside the index, and branch_taken_i = flag_i for bf, !flag_i for bnf, is derived upstream and passed as prev_taken_i (in, 1: predicted taken bit). Actual taken = prev_taken_i XOR branch_mispredict_o.
- Update pipeline: on res, register upd_valid_q=1, upd_idx_q, upd_taken_q. In the next cycle, write tbl[upd_idx_q] = sat(tbl[upd_idx_q] ± 1), computed from the table value at write time. sat: 3 stays at 3 on taken; 0 stays at 0 on not-taken.
- GHR: updated at res, ghr_q = {ghr_q[GHR_WIDTH-2:0], actual taken}. Non-speculative.
- Bypass: if upd_valid_q and idx == upd_idx_q, the prediction uses the post-update counter value.
- Back-to-back resolves to the same index: the first writes in cycle N+1, the second is latched in N+1 and writes in N+2 from the already-updated value. No update is lost.
- Init FSM:
  - States IDLE and INIT. Reset enters INIT with init_cnt=0.
  - In INIT, each cycle writes tbl[init_cnt]=2'b01 (weakly not-taken) and increments init_cnt.
  - At init_cnt == 2^BHT_INDEX_WIDTH-1, writes the last entry and moves to IDLE.
  - Walk takes 2^BHT_INDEX_WIDTH cycles.
- Reset values:
  - init_busy_o=1, upd_valid_q=0, ghr_q=0, init_cnt=0.
  - predicted_flag_o follows the static rule; branch_mispredict_o is combinational.
  - Table contents are undefined until the walk completes.
- Reset asserted mid-init or mid-update: the pending update is discarded and the walk restarts from 0.
- padv_i=0: outputs still valid; no state change is caused by the predict stage.

Decomposition:
- Shared defines file: counter encodings (STRONG_NT=0, WEAK_NT=1, WEAK_T=2, STRONG_T=3), FSM state encodings.
- One natural sub-module, mor1kx_bht_ctrl_satcnt: the combinational 2-bit saturating next-value function. Used for both the write path and the bypass path.

Test Plan:
- Reset released -> init_busy_o=1 for exactly 64 cycles; during the walk, l.bf with immjbr_upper_i[9]=1 gives predicted_flag_o=1. After the walk, every entry is 01, so l.bf predicts 0.
- Same PC, GHR_WIDTH=0, four consecutive taken resolves -> counter goes 01->10->11->11; prediction flips to taken after the first update, and the saturation holds.
- Resolve taken at cycle N, with a predict at the same index in cycle N+1 -> bypass gives the 10 value: predicted taken in N+1 before the table write is visible.
- l.bnf predicted taken (predicted_flag_o=0), flag_i=1 -> branch_mispredict_o=1 in that cycle. Counter decrements; ghr_q shifts in 0.
- Two branches with identical PC[7:2] and different history -> distinct bht_index_o via XOR. Training one leaves the other at 01.
- rst pulsed at walk cycle 30 with upd_valid_q=1 -> update dropped, init_cnt=0, 64 further cycles of init_busy_o=1.
